// File: rtl/exc_unit.sv
// Exception arbiter / commit stage: prioritises memory-stage exceptions, updates cp0, flushes and redirects fetch.
// Define EXC_TLB_EN to enable the TLB exception classes, EntryHi update and refill-vector selection.
module exc_unit #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VECTOR = 32'hBFC0_0200,
  parameter int unsigned FLUSH_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [31:0] m_mem_addr,
  input  logic        m_if_adel,
  input  logic        m_ri,
  input  logic        m_ov,
  input  logic        m_syscall,
  input  logic        m_break,
  input  logic        m_d_adel,
  input  logic        m_d_ades,
  input  logic        m_if_tlbl,
  input  logic        m_d_tlbl,
  input  logic        m_d_tlbs,
  input  logic        m_d_mod,
  input  logic        m_tlb_refill,
  input  logic        m_eret,
  input  logic        cp0_has_int,
  input  logic        cp0_status_exl,
  input  logic        cp0_cause_bd,
  input  logic [31:0] cp0_epc,
  output logic        w_cp0_update_ena,
  output logic [4:0]  w_cp0_exccode,
  output logic        w_cp0_bd,
  output logic        w_cp0_exl,
  output logic [31:0] w_cp0_epc,
  output logic        w_cp0_badvaddr_ena,
  output logic [31:0] w_cp0_badvaddr,
  output logic        w_cp0_entryhi_ena,
  output logic [31:0] w_cp0_entryhi,
  output logic        cp0_cls_exl,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;

  logic        w_if_tlbl, w_d_tlbl, w_d_tlbs, w_d_mod, w_refill;
  logic        w_exc, w_bva_ena, w_tlb, w_tlbls;
  logic [4:0]  w_code;
  logic [31:0] w_bva;
  logic        w_take, w_eret;
  logic [31:0] w_redir_pc;

`ifdef EXC_TLB_EN
  assign w_if_tlbl = m_if_tlbl;
  assign w_d_tlbl  = m_d_tlbl;
  assign w_d_tlbs  = m_d_tlbs;
  assign w_d_mod   = m_d_mod;
  assign w_refill  = m_tlb_refill;
`else
  logic w_unused_tlb;
  assign w_unused_tlb = ^{m_if_tlbl, m_d_tlbl, m_d_tlbs, m_d_mod, m_tlb_refill};
  assign w_if_tlbl = 1'b0;
  assign w_d_tlbl  = 1'b0;
  assign w_d_tlbs  = 1'b0;
  assign w_d_mod   = 1'b0;
  assign w_refill  = 1'b0;
`endif

  // MIPS priority: first matching cause wins; w_tlbls marks TLBL/TLBS for refill selection.
  always_comb begin
    w_exc     = 1'b1;
    w_code    = 5'd0;
    w_bva_ena = 1'b0;
    w_bva     = m_pc;
    w_tlb     = 1'b0;
    w_tlbls   = 1'b0;
    if (cp0_has_int)    w_code = 5'd0;
    else if (m_if_adel) begin w_code = 5'd4; w_bva_ena = 1'b1; end
    else if (w_if_tlbl) begin w_code = 5'd2; w_bva_ena = 1'b1; w_tlb = 1'b1; w_tlbls = 1'b1; end
    else if (m_ri)      w_code = 5'd10;
    else if (m_syscall) w_code = 5'd8;
    else if (m_break)   w_code = 5'd9;
    else if (m_ov)      w_code = 5'd12;
    else if (m_d_adel)  begin w_code = 5'd4; w_bva_ena = 1'b1; w_bva = m_mem_addr; end
    else if (m_d_ades)  begin w_code = 5'd5; w_bva_ena = 1'b1; w_bva = m_mem_addr; end
    else if (w_d_tlbl)  begin w_code = 5'd2; w_bva_ena = 1'b1; w_bva = m_mem_addr; w_tlb = 1'b1; w_tlbls = 1'b1; end
    else if (w_d_tlbs)  begin w_code = 5'd3; w_bva_ena = 1'b1; w_bva = m_mem_addr; w_tlb = 1'b1; w_tlbls = 1'b1; end
    else if (w_d_mod)   begin w_code = 5'd1; w_bva_ena = 1'b1; w_bva = m_mem_addr; w_tlb = 1'b1; end
    else                w_exc = 1'b0;
  end

  assign w_take = (r_state == ST_IDLE) && m_valid && w_exc;
  assign w_eret = (r_state == ST_IDLE) && m_valid && !w_exc && m_eret;

  always_comb begin
    w_redir_pc = cp0_epc;
    if (w_take)
      w_redir_pc = (w_tlbls && w_refill && !cp0_status_exl) ? REFILL_VECTOR : EXC_VECTOR;
  end

  // The last flush cycle overlaps the first IDLE cycle, so events are accepted at N+FLUSH_CYCLES.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_take || w_eret) begin
          w_cnt_nxt   = LP_CNT_LOAD;
          w_state_nxt = (LP_CNT_LOAD == 4'd0) ? ST_IDLE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cp0_update_ena   <= 1'b0;
      w_cp0_exccode      <= 5'd0;
      w_cp0_bd           <= 1'b0;
      w_cp0_exl          <= 1'b0;
      w_cp0_epc          <= 32'd0;
      w_cp0_badvaddr_ena <= 1'b0;
      w_cp0_badvaddr     <= 32'd0;
      cp0_cls_exl        <= 1'b0;
      flush              <= 1'b0;
      redirect_valid     <= 1'b0;
      redirect_pc        <= 32'd0;
    end else begin
      w_cp0_update_ena   <= w_take;
      w_cp0_badvaddr_ena <= w_take && w_bva_ena;
      cp0_cls_exl        <= w_eret;
      redirect_valid     <= w_take || w_eret;
      flush              <= w_take || w_eret || (r_state == ST_FLUSH);
      if (w_take) begin
        w_cp0_exccode <= w_code;
        w_cp0_exl     <= 1'b1;
        // A nested exception (EXL already set) must not clobber the original EPC/BD.
        if (cp0_status_exl) begin
          w_cp0_epc <= cp0_epc;
          w_cp0_bd  <= cp0_cause_bd;
        end else begin
          w_cp0_epc <= m_bd ? (m_pc - 32'd4) : m_pc;
          w_cp0_bd  <= m_bd;
        end
      end
      if (w_take && w_bva_ena) w_cp0_badvaddr <= w_bva;
      if (w_take || w_eret)    redirect_pc    <= w_redir_pc;
    end
  end

`ifdef EXC_TLB_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cp0_entryhi_ena <= 1'b0;
      w_cp0_entryhi     <= 32'd0;
    end else begin
      w_cp0_entryhi_ena <= w_take && w_tlb;
      if (w_take && w_tlb) w_cp0_entryhi <= w_bva;
    end
  end
`else
  logic w_unused_tlbcls;
  assign w_unused_tlbcls   = w_tlb;
  assign w_cp0_entryhi_ena = 1'b0;
  assign w_cp0_entryhi     = 32'd0;
`endif

endmodule

// File: tb/tb_exc_unit.sv
// Directed self-checking bench for exc_unit (default FLUSH_CYCLES=2).
// TLB scenarios follow the EXC_TLB_EN build setting.
module tb_exc_unit;

  logic        clk, rst;
  logic        m_valid, m_bd;
  logic [31:0] m_pc, m_mem_addr;
  logic        m_if_adel, m_ri, m_ov, m_syscall, m_break, m_d_adel, m_d_ades;
  logic        m_if_tlbl, m_d_tlbl, m_d_tlbs, m_d_mod, m_tlb_refill, m_eret;
  logic        cp0_has_int, cp0_status_exl, cp0_cause_bd;
  logic [31:0] cp0_epc;
  logic        w_cp0_update_ena, w_cp0_bd, w_cp0_exl, w_cp0_badvaddr_ena, w_cp0_entryhi_ena;
  logic [4:0]  w_cp0_exccode;
  logic [31:0] w_cp0_epc, w_cp0_badvaddr, w_cp0_entryhi, redirect_pc;
  logic        cp0_cls_exl, flush, redirect_valid;

  int checks   = 0;
  int failures = 0;

  // Priority table: flag bits {if_adel, ri, sys, brk, ov, d_adel, d_ades}.
  logic [6:0] priFlags [0:6] = '{7'b1100010, 7'b0110100, 7'b0011000, 7'b0001101,
                                 7'b0000110, 7'b0000011, 7'b0000001};
  logic [4:0] priCode  [0:6] = '{5'd4, 5'd10, 5'd8, 5'd9, 5'd12, 5'd4, 5'd5};
  logic [1:0] priBva   [0:6] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};

  exc_unit dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd), .m_mem_addr(m_mem_addr),
    .m_if_adel(m_if_adel), .m_ri(m_ri), .m_ov(m_ov), .m_syscall(m_syscall), .m_break(m_break),
    .m_d_adel(m_d_adel), .m_d_ades(m_d_ades), .m_if_tlbl(m_if_tlbl), .m_d_tlbl(m_d_tlbl),
    .m_d_tlbs(m_d_tlbs), .m_d_mod(m_d_mod), .m_tlb_refill(m_tlb_refill), .m_eret(m_eret),
    .cp0_has_int(cp0_has_int), .cp0_status_exl(cp0_status_exl), .cp0_cause_bd(cp0_cause_bd),
    .cp0_epc(cp0_epc), .w_cp0_update_ena(w_cp0_update_ena), .w_cp0_exccode(w_cp0_exccode),
    .w_cp0_bd(w_cp0_bd), .w_cp0_exl(w_cp0_exl), .w_cp0_epc(w_cp0_epc),
    .w_cp0_badvaddr_ena(w_cp0_badvaddr_ena), .w_cp0_badvaddr(w_cp0_badvaddr),
    .w_cp0_entryhi_ena(w_cp0_entryhi_ena), .w_cp0_entryhi(w_cp0_entryhi),
    .cp0_cls_exl(cp0_cls_exl), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task clearInputs;
    m_valid = 0; m_bd = 0; m_pc = 0; m_mem_addr = 0;
    m_if_adel = 0; m_ri = 0; m_ov = 0; m_syscall = 0; m_break = 0; m_d_adel = 0; m_d_ades = 0;
    m_if_tlbl = 0; m_d_tlbl = 0; m_d_tlbs = 0; m_d_mod = 0; m_tlb_refill = 0; m_eret = 0;
    cp0_has_int = 0; cp0_status_exl = 0; cp0_cause_bd = 0; cp0_epc = 0;
  endtask

  task tick;
    @(posedge clk); #1;
  endtask

  // Drop the instruction and let the two-cycle flush drain.
  task settle;
    @(negedge clk); clearInputs();
    tick(); tick();
  endtask

  task test_reset;
    clearInputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (w_cp0_update_ena !== 1'b0) begin failures++; $display("[TB] FAIL reset_update got %b exp 0", w_cp0_update_ena); end
    checks++; if (w_cp0_exccode !== 5'd0) begin failures++; $display("[TB] FAIL reset_exccode got %0d exp 0", w_cp0_exccode); end
    checks++; if (w_cp0_epc !== 32'd0) begin failures++; $display("[TB] FAIL reset_epc got %h exp 0", w_cp0_epc); end
    checks++; if ({flush, redirect_valid, cp0_cls_exl, w_cp0_exl, w_cp0_bd} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flags got %b exp 00000", {flush, redirect_valid, cp0_cls_exl, w_cp0_exl, w_cp0_bd}); end
    checks++; if (redirect_pc !== 32'd0) begin failures++; $display("[TB] FAIL reset_redirect_pc got %h exp 0", redirect_pc); end
    @(negedge clk); rst = 1;
  endtask

  task test_ri;
    @(negedge clk); clearInputs(); m_valid = 1; m_ri = 1; m_pc = 32'h8000_1000;
    tick();
    checks++; if (w_cp0_update_ena !== 1'b1) begin failures++; $display("[TB] FAIL ri_update got %b exp 1", w_cp0_update_ena); end
    checks++; if (w_cp0_exccode !== 5'd10) begin failures++; $display("[TB] FAIL ri_exccode got %0d exp 10", w_cp0_exccode); end
    checks++; if (w_cp0_epc !== 32'h8000_1000) begin failures++; $display("[TB] FAIL ri_epc got %h exp 80001000", w_cp0_epc); end
    checks++; if (redirect_pc !== 32'hBFC0_0380 || redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL ri_redirect got %b/%h exp 1/bfc00380", redirect_valid, redirect_pc); end
    checks++; if (flush !== 1'b1 || w_cp0_exl !== 1'b1 || w_cp0_badvaddr_ena !== 1'b0) begin failures++; $display("[TB] FAIL ri_flush_exl_bva got %b%b%b exp 110", flush, w_cp0_exl, w_cp0_badvaddr_ena); end
    @(negedge clk); clearInputs();
    tick();
    checks++; if (flush !== 1'b1 || w_cp0_update_ena !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL ri_cycle2 flush/upd/rv got %b%b%b exp 100", flush, w_cp0_update_ena, redirect_valid); end
    checks++; if (w_cp0_exccode !== 5'd10) begin failures++; $display("[TB] FAIL ri_exccode_hold got %0d exp 10", w_cp0_exccode); end
    tick();
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL ri_flush_end got %b exp 0", flush); end
  endtask

  task test_data_adel;
    @(negedge clk); clearInputs(); m_valid = 1; m_d_adel = 1; m_bd = 1;
    m_pc = 32'h8000_2004; m_mem_addr = 32'h0000_0003;
    tick();
    checks++; if (w_cp0_exccode !== 5'd4 || w_cp0_bd !== 1'b1) begin failures++; $display("[TB] FAIL adel_code_bd got %0d/%b exp 4/1", w_cp0_exccode, w_cp0_bd); end
    checks++; if (w_cp0_epc !== 32'h8000_2000) begin failures++; $display("[TB] FAIL adel_epc got %h exp 80002000", w_cp0_epc); end
    checks++; if (w_cp0_badvaddr_ena !== 1'b1 || w_cp0_badvaddr !== 32'h3) begin failures++; $display("[TB] FAIL adel_badvaddr got %b/%h exp 1/00000003", w_cp0_badvaddr_ena, w_cp0_badvaddr); end
    settle();
    // Delay-slot EPC wraps below address zero.
    @(negedge clk); clearInputs(); m_valid = 1; m_ov = 1; m_bd = 1; m_pc = 32'h0;
    tick();
    checks++; if (w_cp0_epc !== 32'hFFFF_FFFC || w_cp0_exccode !== 5'd12) begin failures++; $display("[TB] FAIL epc_wrap got %h/%0d exp fffffffc/12", w_cp0_epc, w_cp0_exccode); end
    settle();
  endtask

  task test_int_flush_ignore;
    @(negedge clk); clearInputs(); m_valid = 1; cp0_has_int = 1; m_syscall = 1; m_pc = 32'h8000_4000;
    tick();
    checks++; if (w_cp0_update_ena !== 1'b1 || w_cp0_exccode !== 5'd0) begin failures++; $display("[TB] FAIL int_code got %b/%0d exp 1/0", w_cp0_update_ena, w_cp0_exccode); end
    checks++; if (w_cp0_epc !== 32'h8000_4000) begin failures++; $display("[TB] FAIL int_epc got %h exp 80004000", w_cp0_epc); end
    @(negedge clk); clearInputs(); m_valid = 1; m_break = 1; cp0_has_int = 1; m_pc = 32'h8000_4004;
    tick();
    checks++; if (w_cp0_update_ena !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_ignore got upd=%b rv=%b exp 0/0", w_cp0_update_ena, redirect_valid); end
    checks++; if (w_cp0_exccode !== 5'd0) begin failures++; $display("[TB] FAIL flush_ignore_code got %0d exp 0", w_cp0_exccode); end
    @(negedge clk); clearInputs();
    tick();
    checks++; if (flush !== 1'b0 || w_cp0_update_ena !== 1'b0) begin failures++; $display("[TB] FAIL flush_ignore_end got %b/%b exp 0/0", flush, w_cp0_update_ena); end
  endtask

  task test_eret;
    @(negedge clk); clearInputs(); m_valid = 1; m_eret = 1; cp0_epc = 32'h8000_0100;
    tick();
    checks++; if (cp0_cls_exl !== 1'b1 || w_cp0_update_ena !== 1'b0) begin failures++; $display("[TB] FAIL eret_strobes got cls=%b upd=%b exp 1/0", cp0_cls_exl, w_cp0_update_ena); end
    checks++; if (redirect_pc !== 32'h8000_0100 || redirect_valid !== 1'b1 || flush !== 1'b1) begin failures++; $display("[TB] FAIL eret_redirect got %h/%b/%b exp 80000100/1/1", redirect_pc, redirect_valid, flush); end
    @(negedge clk); clearInputs();
    tick();
    checks++; if (cp0_cls_exl !== 1'b0) begin failures++; $display("[TB] FAIL eret_cls_width got %b exp 0", cp0_cls_exl); end
    tick();
    // An exception on the same instruction overrides ERET.
    @(negedge clk); clearInputs(); m_valid = 1; m_eret = 1; m_ov = 1; m_pc = 32'h8000_0200; cp0_epc = 32'h1234_0000;
    tick();
    checks++; if (cp0_cls_exl !== 1'b0 || w_cp0_update_ena !== 1'b1 || w_cp0_exccode !== 5'd12) begin failures++; $display("[TB] FAIL eret_vs_ov got cls=%b upd=%b code=%0d exp 0/1/12", cp0_cls_exl, w_cp0_update_ena, w_cp0_exccode); end
    checks++; if (redirect_pc !== 32'hBFC0_0380) begin failures++; $display("[TB] FAIL eret_vs_ov_pc got %h exp bfc00380", redirect_pc); end
    settle();
  endtask

  task test_exl_preserve;
    @(negedge clk); clearInputs(); m_valid = 1; m_syscall = 1; m_pc = 32'h8000_5000; m_bd = 0;
    cp0_status_exl = 1; cp0_epc = 32'h1234_5678; cp0_cause_bd = 1;
    tick();
    checks++; if (w_cp0_epc !== 32'h1234_5678 || w_cp0_bd !== 1'b1) begin failures++; $display("[TB] FAIL exl_preserve got %h/%b exp 12345678/1", w_cp0_epc, w_cp0_bd); end
    checks++; if (w_cp0_exccode !== 5'd8) begin failures++; $display("[TB] FAIL exl_code got %0d exp 8", w_cp0_exccode); end
    settle();
  endtask

  task test_priority;
    logic [31:0] expBva;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); clearInputs(); m_valid = 1; m_pc = 32'h8000_3000 + 32'(i * 4); m_mem_addr = 32'h1000_0007;
      {m_if_adel, m_ri, m_syscall, m_break, m_ov, m_d_adel, m_d_ades} = priFlags[i];
      expBva = (priBva[i] == 2'd1) ? (32'h8000_3000 + 32'(i * 4)) : 32'h1000_0007;
      tick();
      checks++; if (w_cp0_exccode !== priCode[i] || w_cp0_update_ena !== 1'b1) begin failures++; $display("[TB] FAIL prio%0d_code got %0d/%b exp %0d/1", i, w_cp0_exccode, w_cp0_update_ena, priCode[i]); end
      checks++; if (w_cp0_badvaddr_ena !== (priBva[i] != 2'd0)) begin failures++; $display("[TB] FAIL prio%0d_bva_ena got %b exp %b", i, w_cp0_badvaddr_ena, priBva[i] != 2'd0); end
      if (priBva[i] != 2'd0) begin
        checks++; if (w_cp0_badvaddr !== expBva) begin failures++; $display("[TB] FAIL prio%0d_bva got %h exp %h", i, w_cp0_badvaddr, expBva); end
      end
      settle();
    end
  endtask

  task test_back_to_back;
    @(negedge clk); clearInputs(); m_valid = 1; m_ri = 1; m_pc = 32'h8000_6000;
    tick();
    checks++; if (w_cp0_exccode !== 5'd10) begin failures++; $display("[TB] FAIL b2b_first got %0d exp 10", w_cp0_exccode); end
    @(negedge clk); clearInputs();
    tick();
    @(negedge clk); clearInputs(); m_valid = 1; m_syscall = 1; m_pc = 32'h8000_6008;
    tick();
    checks++; if (w_cp0_update_ena !== 1'b1 || w_cp0_exccode !== 5'd8 || flush !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second got upd=%b code=%0d flush=%b exp 1/8/1", w_cp0_update_ena, w_cp0_exccode, flush); end
    checks++; if (w_cp0_epc !== 32'h8000_6008) begin failures++; $display("[TB] FAIL b2b_epc got %h exp 80006008", w_cp0_epc); end
    settle();
  endtask

  task test_idle_invalid;
    @(negedge clk); clearInputs(); m_valid = 0; m_ri = 1; m_eret = 1; cp0_has_int = 1;
    tick();
    checks++; if ({w_cp0_update_ena, cp0_cls_exl, redirect_valid, flush} !== 4'b0) begin failures++; $display("[TB] FAIL invalid_idle got %b exp 0000", {w_cp0_update_ena, cp0_cls_exl, redirect_valid, flush}); end
    @(negedge clk); clearInputs();
  endtask

  task test_tlb;
`ifdef EXC_TLB_EN
    @(negedge clk); clearInputs(); m_valid = 1; m_d_tlbs = 1; m_tlb_refill = 1; m_mem_addr = 32'h0040_2000; m_pc = 32'h8000_7000;
    tick();
    checks++; if (w_cp0_exccode !== 5'd3 || w_cp0_entryhi_ena !== 1'b1 || w_cp0_entryhi !== 32'h0040_2000) begin failures++; $display("[TB] FAIL tlbs_code_entryhi got %0d/%b/%h exp 3/1/00402000", w_cp0_exccode, w_cp0_entryhi_ena, w_cp0_entryhi); end
    checks++; if (redirect_pc !== 32'hBFC0_0200) begin failures++; $display("[TB] FAIL tlbs_refill_pc got %h exp bfc00200", redirect_pc); end
    settle();
    @(negedge clk); clearInputs(); m_valid = 1; m_d_tlbs = 1; m_tlb_refill = 1; m_mem_addr = 32'h0040_2000; m_pc = 32'h8000_7000;
    cp0_status_exl = 1; cp0_epc = 32'h8000_0ABC;
    tick();
    checks++; if (redirect_pc !== 32'hBFC0_0380 || w_cp0_epc !== 32'h8000_0ABC) begin failures++; $display("[TB] FAIL tlbs_exl got %h/%h exp bfc00380/80000abc", redirect_pc, w_cp0_epc); end
    settle();
`else
    @(negedge clk); clearInputs(); m_valid = 1; m_d_tlbs = 1; m_if_tlbl = 1; m_tlb_refill = 1; m_mem_addr = 32'h0040_2000;
    tick();
    checks++; if (w_cp0_update_ena !== 1'b0 || flush !== 1'b0) begin failures++; $display("[TB] FAIL tlb_ignored got upd=%b flush=%b exp 0/0", w_cp0_update_ena, flush); end
    checks++; if (w_cp0_entryhi_ena !== 1'b0 || w_cp0_entryhi !== 32'd0) begin failures++; $display("[TB] FAIL entryhi_off got %b/%h exp 0/0", w_cp0_entryhi_ena, w_cp0_entryhi); end
    @(negedge clk); m_ri = 1;
    tick();
    checks++; if (w_cp0_exccode !== 5'd10 || redirect_pc !== 32'hBFC0_0380) begin failures++; $display("[TB] FAIL tlb_off_ri got %0d/%h exp 10/bfc00380", w_cp0_exccode, redirect_pc); end
    settle();
`endif
  endtask

  task test_reset_mid_flush;
    @(negedge clk); clearInputs(); m_valid = 1; m_ri = 1; m_pc = 32'h8000_8000;
    tick();
    checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre got flush=%b exp 1", flush); end
    #2 rst = 0;
    #1;
    checks++; if ({flush, w_cp0_update_ena, redirect_valid, w_cp0_exl} !== 4'b0) begin failures++; $display("[TB] FAIL midrst_async got %b exp 0000", {flush, w_cp0_update_ena, redirect_valid, w_cp0_exl}); end
    checks++; if (w_cp0_exccode !== 5'd0 || w_cp0_epc !== 32'd0 || redirect_pc !== 32'd0) begin failures++; $display("[TB] FAIL midrst_data got %0d/%h/%h exp 0/0/0", w_cp0_exccode, w_cp0_epc, redirect_pc); end
    @(negedge clk); clearInputs();
    @(negedge clk); rst = 1;
    @(negedge clk); m_valid = 1; m_ov = 1; m_pc = 32'h8000_9000;
    tick();
    checks++; if (w_cp0_update_ena !== 1'b1 || w_cp0_exccode !== 5'd12) begin failures++; $display("[TB] FAIL post_reset_ov got %b/%0d exp 1/12", w_cp0_update_ena, w_cp0_exccode); end
    settle();
  endtask

  initial begin
    rst = 0;
    clearInputs();
    test_reset();
    test_ri();
    test_data_adel();
    test_int_flush_ignore();
    test_eret();
    test_exl_preserve();
    test_priority();
    test_back_to_back();
    test_idle_invalid();
    test_tlb();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
